// File: rtl/imc_controller_seq_if.sv
// imc_controller_seq_if: single-cycle req/gnt data-bus port with registered rvalid
interface imc_controller_seq_if;
    logic        req, we, gnt, rvalid, irq;
    logic [31:0] addr, wdata, rdata;
    modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, irq);
    modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, irq);
endinterface

// File: rtl/imc_controller_seq.sv
// imc_controller_seq: memory-mapped crossbar controller computing COLS dot-products row by row
module imc_controller_seq #(
    parameter int          ROWS      = 8,
    parameter int          COLS      = 8,
    parameter int          W_BITS    = 8,
    parameter int          V_BITS    = 8,
    parameter int          ACC_BITS  = W_BITS + V_BITS + $clog2(ROWS),
    parameter logic [31:0] BASE_ADDR = 32'h400
) (
    input logic clk,
    input logic rst,
    imc_controller_seq_if.slave bus
);
    localparam int N    = ROWS * COLS;
    localparam int PA_W = $clog2(N);
    localparam int RC_W = $clog2(ROWS);
    localparam int CC_W = $clog2(COLS);
    typedef enum logic {IDLE, COMPUTE} state_t;
    state_t state, state_nx;
    logic [RC_W-1:0]     row_cnt;
    logic [PA_W-1:0]     prog_addr;
    logic [W_BITS-1:0]   w [N];
    logic [V_BITS-1:0]   vin [ROWS];
    logic [ACC_BITS-1:0] acc [COLS];
    logic [ACC_BITS-1:0] result [COLS];
    logic [ACC_BITS-1:0] sum [COLS];
    logic irq_en, done, err, busy;
    logic [31:0] off, rd_val;
    logic [5:0] idx;
    logic [3:0] sub;
    logic in_win, wr, is_vin, is_res, start_w, start_ok, last_row, err_set, pa_ok, unused_bits;
    assign off         = bus.addr - BASE_ADDR;
    assign in_win      = bus.addr >= BASE_ADDR && off < 32'd256;
    assign idx         = off[7:2];
    assign sub         = idx[3:0];
    assign is_vin      = idx[5:4] == 2'b01 && {28'd0, sub} < 32'(ROWS);
    assign is_res      = idx[5:4] == 2'b10 && {28'd0, sub} < 32'(COLS);
    assign wr          = bus.req && bus.we && in_win;
    assign busy        = state == COMPUTE;
    assign start_w     = wr && idx == 6'd0 && bus.wdata[0];
    assign start_ok    = start_w && !busy;
    assign last_row    = busy && row_cnt == RC_W'(ROWS - 1);
    assign err_set     = wr && busy && (idx == 6'd2 || idx == 6'd3 || is_vin || start_w);
    assign pa_ok       = 32'(prog_addr) < 32'(N);
    assign bus.gnt     = bus.req;
    assign bus.irq     = irq_en & done;
    assign unused_bits = ^{off[31:8], off[1:0], bus.wdata};
    always_comb begin
        state_nx = state;
        if (start_ok)
            state_nx = COMPUTE;
        else if (last_row)
            state_nx = IDLE;
    end
    // one row of the crossbar per cycle, every column in parallel
    always_comb begin
        for (int c = 0; c < COLS; c++)
            sum[c] = acc[c] + ACC_BITS'(w[PA_W'(int'(row_cnt) * COLS + c)]) * ACC_BITS'(vin[row_cnt]);
    end
    always_comb begin
        rd_val = '0;
        if (in_win) begin
            if (idx == 6'd0)
                rd_val = {29'd0, irq_en, 2'b00};
            else if (idx == 6'd1)
                rd_val = {29'd0, err, done, busy};
            else if (idx == 6'd2)
                rd_val = 32'(prog_addr);
            else if (idx == 6'd3)
                rd_val = pa_ok ? 32'(w[prog_addr]) : 32'd0;
            else if (is_vin)
                rd_val = 32'(vin[RC_W'(sub)]);
            else if (is_res)
                rd_val = 32'(result[CC_W'(sub)]);
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rdata  <= '0;
            bus.rvalid <= 1'b0;
        end else begin
            bus.rvalid <= bus.req;
            if (bus.req && !bus.we)
                bus.rdata <= rd_val;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            prog_addr <= '0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            for (int i = 0; i < N; i++)
                w[i] <= '0;
            for (int r = 0; r < ROWS; r++)
                vin[r] <= '0;
            for (int c = 0; c < COLS; c++) begin
                acc[c]    <= '0;
                result[c] <= '0;
            end
        end else begin
            state <= state_nx;
            if (wr && idx == 6'd0)
                irq_en <= bus.wdata[2];
            // FSM completion beats a same-cycle W1C
            if (last_row)
                done <= 1'b1;
            else if (start_ok || (wr && idx == 6'd1 && bus.wdata[1]))
                done <= 1'b0;
            if (err_set)
                err <= 1'b1;
            else if (wr && idx == 6'd1 && bus.wdata[2])
                err <= 1'b0;
            if (wr && !busy) begin
                if (idx == 6'd2)
                    prog_addr <= bus.wdata[PA_W-1:0];
                if (idx == 6'd3) begin
                    if (pa_ok)
                        w[prog_addr] <= bus.wdata[W_BITS-1:0];
                    prog_addr <= 32'(prog_addr) >= 32'(N - 1) ? '0 : prog_addr + PA_W'(1);
                end
                if (is_vin)
                    vin[RC_W'(sub)] <= bus.wdata[V_BITS-1:0];
            end
            if (start_ok) begin
                row_cnt <= '0;
                for (int c = 0; c < COLS; c++)
                    acc[c] <= '0;
            end else if (busy) begin
                row_cnt <= row_cnt + RC_W'(1);
                for (int c = 0; c < COLS; c++) begin
                    acc[c] <= sum[c];
                    if (last_row)
                        result[c] <= sum[c];
                end
            end
        end
    end
endmodule

// File: doc/imc_controller_seq.md
# imc_controller_seq

Parametrised, memory-mapped in-memory-compute controller. It holds a ROWS x COLS weight array plus an input-voltage vector, and computes all COLS column dot-products with a row-serial multiply-accumulate state machine. Software drives it through batch weight programming with address auto-increment, a start/busy/done/error status model and a level interrupt. It sits on the core data bus and uses the same single-cycle req/gnt, registered-rvalid protocol as the other bus slaves.

## Interface

- ROWS, 8, crossbar rows (input voltages); 2..16
- COLS, 8, crossbar columns (results); 2..16
- W_BITS, 8, unsigned weight width
- V_BITS, 8, unsigned input width
- ACC_BITS, W_BITS+V_BITS+$clog2(ROWS), accumulator width; must be ≤32
- BASE_ADDR, 32'h400, byte base of register window (256-byte aligned)
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  1  bus request
- we  in  1  1 = write, 0 = read
- addr  in  32  byte address
- wdata  in  32  write data
- rdata  out  32  read data, registered
- gnt  out  1  grant, combinational = req
- rvalid  out  1  registered req, one cycle after request
- irq  out  1  level interrupt = irq_en & done

## Operation

- Address decoding: off = addr - BASE_ADDR, decoded only when addr is inside [BASE_ADDR, BASE_ADDR+0xFF]. Unmapped reads return 0. Unmapped writes are ignored.
- 0x00 CTRL:
  - W bit0 start (pulse; also clears done), W bit2 irq_en (stored).
  - R returns {29'b0, irq_en, 2'b0}.
- 0x04 STATUS:
  - R {29'b0, err, done, busy}.
  - W1C on bit1 (done) and bit2 (err).
- 0x08 PROG_ADDR: R/W flat index row*COLS+col, width $clog2(ROWS*COLS).
- 0x0C PROG_DATA:
  - W stores wdata[W_BITS-1:0] at PROG_ADDR, then PROG_ADDR+1, wrapping to 0 after ROWS*COLS-1.
  - R returns the zero-extended weight at PROG_ADDR, with no increment.
- 0x40+4r V_INPUT[r], r<ROWS: R/W, low V_BITS stored.
- 0x80+4c RESULT[c], c<COLS: read-only, zero-extended ACC_BITS. Writes are ignored.
- FSM IDLE → COMPUTE:
  - A start write while IDLE clears acc[*] and row_cnt and enters COMPUTE.
  - Each COMPUTE cycle does acc[c] += w[row_cnt][c]*V_INPUT[row_cnt] for all c in parallel, then row_cnt+1.
  - On row_cnt==ROWS-1: RESULT[c] <= final sum, done<=1, return to IDLE.
- busy = (state==COMPUTE).
- Writes to PROG_ADDR/PROG_DATA/V_INPUT while busy are dropped and set err. Start while busy is ignored and sets err. CTRL irq_en writes and STATUS W1C are always accepted.
- Arithmetic is unsigned. No saturation is needed because ACC_BITS covers the worst case.
- Reset values:
  - rdata=0, rvalid=0, irq=0.
  - state IDLE; busy/done/err/irq_en=0.
  - PROG_ADDR=0; all weights, V_INPUT, acc and RESULT = 0.

## Timing

- A write takes effect at the edge where req&&we is sampled.
- rdata/rvalid update at the edge where req is sampled (read) and show pre-edge register state. rdata holds its value when there is no read.
- Start sampled at edge T:
  - busy=1 for cycles T+1..T+ROWS (exactly ROWS cycles).
  - RESULT, done=1 and busy=0 are visible from edge T+ROWS.
  - irq rises in the same cycle as done.
- A STATUS read in the cycle of edge T returns busy=0. A read whose request is sampled at edge T+1 returns busy=1.
- RESULT holds previous values throughout COMPUTE. Reads during busy are legal.
- Simultaneous events:
  - done set by the FSM and done W1C in the same cycle: set wins.
  - err set and err W1C in the same cycle: set wins.
- Back-to-back PROG_DATA writes on consecutive cycles each increment once.
- A PROG_ADDR write and a PROG_DATA write cannot collide (single bus).
- Reset mid-compute aborts immediately. All state, including RESULT, returns to reset values.

## Test plan

- Reset:
  - Stimulus: assert rst, release, read STATUS and RESULT[0].
  - Required: rvalid=0 and irq=0 during reset; both reads return 0; rvalid high one cycle after each req.
- Batch program:
  - Stimulus: PROG_ADDR=0, then 64 PROG_DATA writes with value k+1 (k=0..63).
  - Required: PROG_ADDR reads 0 (wrapped). After writing PROG_ADDR=9, PROG_DATA reads 10 twice and PROG_ADDR still reads 9.
- Compute:
  - Stimulus: w[r][c]=c+1, V_INPUT[r]=r+1, write start.
  - Required: busy exactly 8 cycles, then done=1 and RESULT[c]=36*(c+1) (RESULT[7]=288).
- Maximum values:
  - Stimulus: all weights and inputs = 255.
  - Required: every RESULT = 520200 (0x7F008).
- Busy protection:
  - Stimulus: during COMPUTE write V_INPUT[0]=0, PROG_DATA=0 and start.
  - Required: err=1 and RESULT matches the pre-write computation. A STATUS write of 0x4 clears err.
- Interrupt and reset abort:
  - Stimulus 1: irq_en=1, start.
  - Required 1: irq rises with done. STATUS W1C 0x2 drops irq the next cycle.
  - Stimulus 2: restart, assert rst on the 4th busy cycle.
  - Required 2: busy=0, done=0, irq=0, RESULT[*]=0.
